// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - instruction-fetch front end with PC, one-entry fetch buffer, redirect and halt
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 32,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] PC_Current,
  input  logic [31:0] Instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        halt,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] FETCH_LIMIT = 32'(IMEM_WORDS * 4);
  localparam logic [31:0] LAST_PC     = FETCH_LIMIT - 32'd4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc_n;
  logic        valid_n;
  logic [31:0] instr_q, instr_n;
  logic [31:0] pc_buf_n, pc4_buf_n;
  logic        err_n;
  logic [31:0] count_n;
  logic        handshake;
  logic        load;
  logic        target_ok;
  logic        target_misaligned;

  assign handshake         = out_valid & out_ready;
  assign load              = ~out_valid | out_ready;
  assign target_misaligned = (redirect_target[1:0] != 2'b00);
  assign target_ok         = ~target_misaligned & (redirect_target < FETCH_LIMIT);

  // The buffer word is only meaningful while valid; otherwise decode sees a NOP.
  assign out_instr = out_valid ? instr_q : NOP_INSTR;
  assign halt      = (state == HALT);

  // State, PC, fetch buffer and counters register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      PC_Current   <= RESET_PC;
      out_valid    <= 1'b0;
      instr_q      <= NOP_INSTR;
      out_pc       <= 32'd0;
      out_pc_plus4 <= 32'd0;
      misalign_err <= 1'b0;
      fetch_count  <= 32'd0;
    end else begin
      state        <= state_n;
      PC_Current   <= pc_n;
      out_valid    <= valid_n;
      instr_q      <= instr_n;
      out_pc       <= pc_buf_n;
      out_pc_plus4 <= pc4_buf_n;
      misalign_err <= err_n;
      fetch_count  <= count_n;
    end
  end

  // Next-state: redirect wins over everything; a same-cycle handshake still counts.
  always_comb begin
    state_n   = state;
    pc_n      = PC_Current;
    valid_n   = out_valid;
    instr_n   = instr_q;
    pc_buf_n  = out_pc;
    pc4_buf_n = out_pc_plus4;
    err_n     = misalign_err;
    count_n   = handshake ? fetch_count + 32'd1 : fetch_count;

    if (redirect_valid) begin
      valid_n = 1'b0;
      if (target_ok) begin
        pc_n    = redirect_target;
        state_n = RUN;
      end else begin
        state_n = HALT;
        if (target_misaligned) begin
          err_n = 1'b1;
        end
      end
    end else begin
      case (state)
        BOOT: begin
          state_n = RUN;
        end
        RUN: begin
          if (load) begin
            instr_n   = Instruction;
            pc_buf_n  = PC_Current;
            pc4_buf_n = PC_Current + 32'd4;
            valid_n   = 1'b1;
            if (PC_Current == LAST_PC) begin
              state_n = HALT;
            end else begin
              pc_n = PC_Current + 32'd4;
            end
          end
        end
        HALT: begin
          if (handshake) begin
            valid_n = 1'b0;
          end
        end
        default: begin
          state_n = HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - scoreboard bench for pc_fetch_unit
module tb_pc_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [31:0] PC_Current;
  logic [31:0] Instruction;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        halt;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  pc_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(32),
    .NOP_INSTR (NOP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .PC_Current     (PC_Current),
    .Instruction    (Instruction),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .halt           (halt),
    .misalign_err   (misalign_err),
    .fetch_count    (fetch_count)
  );

  // Memory image: word at address a is 0xAB00_0000 | a; beyond memory is a poison value.
  assign Instruction = (PC_Current < 32'h80) ? (32'hAB00_0000 | PC_Current) : 32'hDEAD_DEAD;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " pc"}, PC_Current, 32'h0);
    check({tag, " valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, " instr"}, out_instr, NOP);
    check({tag, " out_pc"}, out_pc, 32'h0);
    check({tag, " pc4"}, out_pc_plus4, 32'h0);
    check({tag, " halt"}, {31'd0, halt}, 32'd0);
    check({tag, " err"}, {31'd0, misalign_err}, 32'd0);
    check({tag, " count"}, fetch_count, 32'd0);
  endtask

  // Monitor: every handshake must deliver the next expected PC and its memory word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_delivery: got pc %h expected none", out_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("mon pc", out_pc, e);
        check("mon instr", out_instr, 32'hAB00_0000 | e);
        check("mon pc4", out_pc_plus4, e + 32'd4);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    #12;
    check_reset_values("reset");

    // Test 1: stream words 0..24 back to back.
    for (int i = 0; i < 7; i++) exp_q.push_back(32'(i * 4));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("boot valid", {31'd0, out_valid}, 32'd0);
    check("boot pc", PC_Current, 32'h0);
    for (int i = 0; i < 8; i++) tick();
    out_ready = 1'b0;
    check("t1 count", fetch_count, 32'd7);
    check("t1 out_pc", out_pc, 32'h1C);

    // Test 2: three-cycle stall holds buffer and PC, release delivers next word once.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall valid", {31'd0, out_valid}, 32'd1);
      check("stall out_pc", out_pc, 32'h1C);
      check("stall pc", PC_Current, 32'h20);
    end
    exp_q.push_back(32'h1C);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release out_pc", out_pc, 32'h20);
    check("release count", fetch_count, 32'd8);

    // Test 3: redirect flushes, next cycle delivers target.
    redirect_valid = 1'b1;
    redirect_target = 32'h10;
    tick();
    redirect_valid = 1'b0;
    check("redir valid", {31'd0, out_valid}, 32'd0);
    check("redir instr", out_instr, NOP);
    check("redir pc", PC_Current, 32'h10);
    tick();
    check("redir out_pc", out_pc, 32'h10);
    check("redir out_valid", {31'd0, out_valid}, 32'd1);

    // Redirect in the same cycle as a handshake: count still increments.
    exp_q.push_back(32'h10);
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h40;
    tick();
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    check("redir+hs count", fetch_count, 32'd9);
    check("redir+hs valid", {31'd0, out_valid}, 32'd0);
    check("redir+hs pc", PC_Current, 32'h40);
    tick();
    check("redir2 out_pc", out_pc, 32'h40);

    // Test 4: misaligned target traps, sticky.
    redirect_valid = 1'b1;
    redirect_target = 32'h12;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("mis err", {31'd0, misalign_err}, 32'd1);
      check("mis halt", {31'd0, halt}, 32'd1);
      check("mis valid", {31'd0, out_valid}, 32'd0);
      check("mis pc", PC_Current, 32'h44);
      tick();
    end

    // Test 5: run to end of memory from 0x70.
    redirect_valid = 1'b1;
    redirect_target = 32'h70;
    tick();
    redirect_valid = 1'b0;
    check("resume halt", {31'd0, halt}, 32'd0);
    check("resume err sticky", {31'd0, misalign_err}, 32'd1);
    for (int a = 'h70; a <= 'h7C; a += 4) exp_q.push_back(32'(a));
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("eom halt", {31'd0, halt}, 32'd1);
    check("eom pc", PC_Current, 32'h7C);
    check("eom valid", {31'd0, out_valid}, 32'd0);
    check("eom count", fetch_count, 32'd13);
    tick();
    tick();
    check("eom hold pc", PC_Current, 32'h7C);
    check("eom hold valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h0;
    tick();
    redirect_valid = 1'b0;
    check("restart halt", {31'd0, halt}, 32'd0);
    tick();
    check("restart out_pc", out_pc, 32'h0);
    check("restart instr", out_instr, 32'hAB00_0000);

    // Test 6: async reset mid-stall with a valid buffer.
    check("pre-reset valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrun");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("reboot valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("reboot out_pc", out_pc, 32'h0);
    check("reboot valid2", {31'd0, out_valid}, 32'd1);
    check("reboot pc", PC_Current, 32'h4);

    // Aligned but out-of-range target halts without the error flag.
    redirect_valid = 1'b1;
    redirect_target = 32'h80;
    tick();
    redirect_valid = 1'b0;
    check("oor halt", {31'd0, halt}, 32'd1);
    check("oor err", {31'd0, misalign_err}, 32'd0);
    check("oor pc", PC_Current, 32'h4);
    check("oor valid", {31'd0, out_valid}, 32'd0);

    tick();
    check("queue drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
